// File: rtl/level_ctrl_if.sv
// VGA timing stream bundle shared by the renderer chain; the scene controller only needs vblnk.
interface vga_if;
    logic vblnk;

    modport in  (input  vblnk);
    modport out (output vblnk);
endinterface

// File: rtl/level_ctrl.sv
// Game-flow controller: picks the active scene renderer and blanks between scenes.
// Every scene switch is deferred to the rising edge of vblnk so no visible frame is torn.
module level_ctrl #(
    parameter int NUM_LEVELS   = 3,
    parameter int TRANS_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          vga_in,
    input  logic       start,
    input  logic       level_done,
    input  logic       player_dead,
    output logic [1:0] level_sel,
    output logic       blank_out,
    output logic       win,
    output logic       game_over,
    output logic [2:0] state_o,
    output logic [5:0] trans_cnt
);
    typedef enum logic [2:0] {
        TITLE = 3'd0,
        TRANS = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam logic [1:0] LAST_LVL   = 2'(NUM_LEVELS);
    localparam logic [5:0] TRANS_LAST = 6'(TRANS_FRAMES - 1);

    state_e     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [1:0] next_lvl_q, next_lvl_d;
    logic [5:0] cnt_q, cnt_d;
    logic       pend_start_q, pend_start_d;
    logic       pend_done_q, pend_done_d;
    logic       pend_dead_q, pend_dead_d;
    logic       vblnk_q;
    logic       blank_q, win_q, over_q;

    logic fb, req_start, req_done, req_dead;

    assign fb        = vga_in.vblnk & ~vblnk_q;
    assign req_start = pend_start_q | start;
    assign req_done  = pend_done_q  | level_done;
    assign req_dead  = pend_dead_q  | player_dead;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        next_lvl_d = next_lvl_q;
        cnt_d      = cnt_q;
        // Requests live for one frame only: consumed or dropped at each boundary.
        pend_start_d = fb ? 1'b0 : req_start;
        pend_done_d  = fb ? 1'b0 : req_done;
        pend_dead_d  = fb ? 1'b0 : req_dead;

        case (state_q)
            TITLE: if (fb && req_start) begin
                state_d    = TRANS;
                next_lvl_d = 2'd1;
                cnt_d      = '0;
            end
            TRANS: if (fb) begin
                if (cnt_q == TRANS_LAST) begin
                    state_d = PLAY;
                    level_d = next_lvl_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            PLAY: if (fb) begin
                if (req_dead) begin
                    state_d = OVER;
                end else if (req_done) begin
                    if (level_q == LAST_LVL) begin
                        state_d = WIN;
                    end else begin
                        state_d    = TRANS;
                        next_lvl_d = level_q + 2'd1;
                        cnt_d      = '0;
                    end
                end
            end
            WIN, OVER: if (fb && req_start) begin
                state_d = TITLE;
                level_d = '0;
            end
            default: begin
                state_d = TITLE;
                level_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= TITLE;
            level_q      <= '0;
            next_lvl_q   <= '0;
            cnt_q        <= '0;
            pend_start_q <= 1'b0;
            pend_done_q  <= 1'b0;
            pend_dead_q  <= 1'b0;
            // Starts high so a vblnk already asserted at release is not seen as a boundary.
            vblnk_q      <= 1'b1;
            blank_q      <= 1'b0;
            win_q        <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            next_lvl_q   <= next_lvl_d;
            cnt_q        <= cnt_d;
            pend_start_q <= pend_start_d;
            pend_done_q  <= pend_done_d;
            pend_dead_q  <= pend_dead_d;
            vblnk_q      <= vga_in.vblnk;
            blank_q      <= (state_d == TRANS);
            win_q        <= (state_d == WIN);
            over_q       <= (state_d == OVER);
        end
    end

    assign state_o   = state_q;
    assign level_sel = level_q;
    assign trans_cnt = cnt_q;
    assign blank_out = blank_q;
    assign win       = win_q;
    assign game_over = over_q;
endmodule
